// File: rtl/logic_seq_64_if.sv
// logic_seq_64_if: valid/ready request and response bundle for the logic sequencer
interface logic_seq_64_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_result;
  logic        resp_zero;
  logic        resp_err;
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_err
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_err
  );
endinterface

// File: rtl/logic_seq_64.sv
// logic_seq_64: 64-bit AND/OR/XOR sequencer time-sharing one SLICE_W-bit logic slice
module logic_seq_64 #(
  parameter int SLICE_W = 16
) (
  input logic           clk,
  input logic           rst,
  logic_seq_64_if.slave bus_io
);
  localparam int NBEATS = 64 / SLICE_W;
  localparam int KW = NBEATS > 1 ? $clog2(NBEATS) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [1:0]         op_q, op_d;
  logic [63:0]        a_q, a_d, b_q, b_d, res_q, res_d;
  logic               nz_q, nz_d, zero_q, zero_d, err_q, err_d;
  logic [5:0]         sh;
  logic [SLICE_W-1:0] sa, sb, sr;
  logic               last;
  assign sh   = 6'(int'(k_q) * SLICE_W);
  assign sa   = a_q[sh +: SLICE_W];
  assign sb   = b_q[sh +: SLICE_W];
  // illegal op 11 forces every slice to zero so the result and zero flag fall out naturally
  assign sr   = op_q == 2'b00 ? sa & sb :
                op_q == 2'b01 ? sa | sb :
                op_q == 2'b10 ? sa ^ sb : '0;
  assign last = k_q == KW'(NBEATS - 1);
  assign bus_io.req_ready   = state_q == IDLE && !rst;
  assign bus_io.resp_valid  = state_q == DONE;
  assign bus_io.resp_result = res_q;
  assign bus_io.resp_zero   = zero_q;
  assign bus_io.resp_err    = err_q;
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    nz_d    = nz_q;
    zero_d  = zero_q;
    err_d   = err_q;
    if (state_q == IDLE && bus_io.req_valid) begin
      state_d = BUSY;
      op_d    = bus_io.req_op;
      a_d     = bus_io.req_a;
      b_d     = bus_io.req_b;
      res_d   = '0;
      nz_d    = 1'b0;
      k_d     = '0;
      zero_d  = 1'b0;
      err_d   = &bus_io.req_op;
    end
    if (state_q == BUSY) begin
      res_d[sh +: SLICE_W] = sr;
      nz_d = nz_q | (|sr);
      k_d  = k_q + 1'b1;
      // the last beat's slice is not yet in nz_q, so merge it directly into the flag
      if (last) begin
        state_d = DONE;
        zero_d  = ~(nz_q | (|sr));
      end
    end
    if (state_q == DONE && bus_io.resp_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      nz_q    <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      nz_q    <= nz_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_logic_seq_64.sv
// tb_logic_seq_64: randomized and directed checks of logic_seq_64 against a transaction-level model
module tb_logic_seq_64;
  localparam int SW = 16;
  localparam int NB = 64 / SW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic_seq_64_if io();
  logic_seq_64 #(.SLICE_W(SW)) dut (.clk(clk), .rst(rst), .bus_io(io));
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0, cyc = 0, acc_cyc = 0, n_done = 0, rr_mode = 0;
  bit pend = 1'b0, after_rst = 1'b0;
  logic [63:0] m_res;
  logic m_err;
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return 64'd0;
    endcase
  endfunction
  // transaction-level model: one outstanding request, response due NB+1 samples after acceptance
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("req_ready_in_reset", 64'(io.req_ready), 64'(0));
      pend = 1'b0;
      after_rst = 1'b1;
    end else begin
      bit ev;
      if (after_rst) begin
        chk("reset_result", io.resp_result, 64'd0);
        chk("reset_zero", 64'(io.resp_zero), 64'(0));
        chk("reset_err", 64'(io.resp_err), 64'(0));
        after_rst = 1'b0;
      end
      ev = pend && (cyc >= acc_cyc + NB + 1);
      chk("req_ready", 64'(io.req_ready), 64'(!pend));
      chk("resp_valid", 64'(io.resp_valid), 64'(ev));
      if (ev) begin
        chk("resp_result", io.resp_result, m_res);
        chk("resp_zero", 64'(io.resp_zero), 64'(m_res == 64'd0));
        chk("resp_err", 64'(io.resp_err), 64'(m_err));
      end
      if (ev && io.resp_ready) begin
        pend = 1'b0;
        n_done++;
      end else if (!pend && io.req_valid) begin
        pend = 1'b1;
        acc_cyc = cyc;
        m_res = ref_op(io.req_op, io.req_a, io.req_b);
        m_err = io.req_op == 2'b11;
      end
    end
  end
  initial begin
    io.resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      io.resp_ready = rr_mode == 2 ? 1'($urandom_range(0, 1)) : rr_mode == 0;
    end
  end
  task automatic accept_wait();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (io.req_ready) break;
      if (++n > 200) begin
        timeout("accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    io.req_valid = 1'b0;
    io.req_a = {$urandom, $urandom};
    io.req_b = {$urandom, $urandom};
    io.req_op = 2'($urandom_range(0, 3));
  endtask
  task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    io.req_valid = 1'b1;
    io.req_op = op;
    io.req_a = a;
    io.req_b = b;
    accept_wait();
  endtask
  task automatic wait_valid(output logic [63:0] r, output logic z, output logic e, output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (io.resp_valid) break;
      if (lat > 200) begin
        timeout("resp_valid");
        break;
      end
      @(posedge clk);
      lat++;
    end
    r = io.resp_result;
    z = io.resp_zero;
    e = io.resp_err;
    @(posedge clk);
    #1;
  endtask
  task automatic run_dir(input string nm, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic ez, input logic ee, input bit chk_lat);
    logic [63:0] r;
    logic z, e;
    int lat;
    send(op, a, b);
    wait_valid(r, z, e, lat);
    chk({nm, "_result"}, r, er);
    chk({nm, "_zero"}, 64'(z), 64'(ez));
    chk({nm, "_err"}, 64'(e), 64'(ee));
    if (chk_lat) chk({nm, "_latency"}, 64'(lat), 64'd4);
  endtask
  initial begin
    logic [63:0] r;
    logic z, e;
    int lat, done0, n;
    io.req_valid = 1'b0;
    io.req_op = 2'b00;
    io.req_a = '0;
    io.req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_dir("and", 2'b00, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0000_0F0F_0000, 1'b0, 1'b0, 1'b1);
    run_dir("xor_eq", 2'b10, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b1, 1'b0, 1'b0);
    run_dir("or_top", 2'b01, 64'h8000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    run_dir("illegal", 2'b11, '1, '1, 64'd0, 1'b1, 1'b1, 1'b0);
    // backpressure with a competing request held on the bus
    rr_mode = 1;
    @(posedge clk);
    #1;
    send(2'b00, 64'h1234_5678_9ABC_DEF0, 64'hFF00_FF00_FF00_FF00);
    wait_valid(r, z, e, lat);
    chk("bp_result", r, 64'h1200_5600_9A00_DE00);
    chk("bp_zero", 64'(z), 64'(0));
    io.req_valid = 1'b1;
    repeat (10) begin
      io.req_op = 2'($urandom_range(0, 2));
      io.req_a = {$urandom, $urandom};
      io.req_b = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    io.req_op = 2'b01;
    io.req_a = 64'hF0;
    io.req_b = 64'h0F;
    done0 = n_done;
    rr_mode = 0;
    accept_wait();
    chk("bp_delivered_once", 64'(n_done - done0), 64'd1);
    wait_valid(r, z, e, lat);
    chk("bp_next_result", r, 64'hFF);
    // reset at beat 2 of an AND
    send(2'b00, '1, '1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(io.req_ready), 64'(1));
    chk("valid_after_reset", 64'(io.resp_valid), 64'(0));
    repeat (8) @(posedge clk);
    #1;
    run_dir("or_after_rst", 2'b01, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0, 1'b1);
    // randomized traffic under random backpressure
    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ;
        1: b = a;
        2: b = '0;
        default: begin
          a = 64'd1 << $urandom_range(0, 63);
          b = '0;
        end
      endcase
      send(2'($urandom_range(0, 3)), a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rr_mode = 0;
    n = 0;
    while (pend && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (pend) timeout("drain");
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/logic_seq_64.md
# logic_seq_64

Multi-cycle sequencer for the 64-bit bitwise logic datapath (AND/OR/XOR plus zero-flag detect). It accepts one operation over a valid/ready request port, time-shares a single SLICE_W-bit logic slice across the operand width, and accumulates the 64-bit result. It returns the result, zero flag and error flag over a valid/ready response port. It sits between the ALU decode/issue stage and the ALU result mux, and replaces a full-width combinational logic unit where area matters more than latency.

## Interface
- SLICE_W, 16, width of the shared logic slice; legal values 4, 8, 16, 32, 64; NBEATS = 64/SLICE_W
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high only in IDLE and never while rst=1
- req_op  in  2  00 AND, 01 OR, 10 XOR, 11 illegal
- req_a  in  64  operand A
- req_b  in  64  operand B
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_result  out  64  a op b
- resp_zero  out  1  1 when resp_result == 0
- resp_err  out  1  1 when the op was illegal

## Operation
- States:
  - IDLE: req_ready=1.
  - BUSY: beat counter k runs 0..NBEATS-1.
  - DONE: resp_valid=1.
- IDLE -> BUSY on req_valid && req_ready. At that edge:
  - latch req_op, req_a and req_b into internal registers;
  - clear the result register and the nonzero accumulator;
  - set k=0.
- Each BUSY cycle:
  - the slice computes latched_a[k*SLICE_W +: SLICE_W] op latched_b[same];
  - at the edge, the slice result is written into result bits [k*SLICE_W +: SLICE_W];
  - nonzero_acc |= (slice result != 0);
  - k increments.
- BUSY -> DONE on the edge that writes beat NBEATS-1. At that edge, zero <= ~(nonzero_acc | current slice nonzero).
- DONE -> IDLE on resp_valid && resp_ready.
- Illegal op (11):
  - the request is accepted and sequenced normally, but every slice result is forced to 0;
  - completes with resp_result=0, resp_zero=1, resp_err=1.
- Legal ops complete with resp_err=0.
- Request inputs are ignored outside IDLE. No queueing, and no request is lost: the requester holds req_valid until req_ready.
- Operand registers are not modified after acceptance. Input changes during BUSY have no effect.
- resp_result, resp_zero and resp_err are stable from entry to DONE until the handshake, including under arbitrary resp_ready backpressure.
- Reset values: state IDLE, k=0, req_ready=0 while rst=1 (1 from the first cycle after release), resp_valid=0, resp_result=0, resp_zero=0, resp_err=0.
- Reset mid-operation (BUSY or DONE) aborts the operation. No response is produced for the aborted request.

## Timing
- Accept on edge E0.
- Slices are written on edges E1..E_NBEATS.
- resp_valid rises after edge E_NBEATS (4 cycles after acceptance for SLICE_W=16; 1 cycle for SLICE_W=64).
- With resp_ready=1 held:
  - the handshake completes on the first DONE edge;
  - req_ready is high the following cycle;
  - minimum request-to-request spacing is NBEATS+2 cycles.
- No combinational path from req_valid to req_ready or from resp_ready to resp_valid.
- All outputs are driven from registers or from the state register only.

## Test plan
- AND, SLICE_W=16, a=64'hFFFF_0000_FFFF_0000, b=64'h0F0F_0F0F_0F0F_0F0F, resp_ready=1:
  - resp_valid rises exactly 4 cycles after acceptance;
  - result=64'h0F0F_0000_0F0F_0000, zero=0, err=0.
- XOR, a=b=64'hDEAD_BEEF_CAFE_F00D:
  - result=0, zero=1, err=0.
- OR, a=64'h8000_0000_0000_0000, b=0 (nonzero only in the top slice):
  - result=64'h8000_0000_0000_0000, zero=0 (checks the final-beat zero merge).
- Backpressure and ignored requests:
  - hold resp_ready=0 for 10 cycles after resp_valid while driving a new req_valid with changing operands;
  - req_ready stays 0 and result, zero, err are stable;
  - after resp_ready=1, the original result is delivered once and the pending request is then accepted.
- Illegal op 11 with a=b=64'hFFFF_FFFF_FFFF_FFFF:
  - result=0, zero=1, err=1;
  - block returns to IDLE.
- Reset mid-operation:
  - assert rst for 1 cycle at beat 2 of an AND;
  - resp_valid never rises for that request and all outputs read reset values;
  - req_ready=1 one cycle after rst falls;
  - a following OR of 1|2 returns 3 with normal latency.
